// File: rtl/sspram_param_if.sv
// Access bus of the parametrised single-port slice RAM: user side drives
// ce/we/ad/di, the RAM returns combinational f, registered q and busy.
interface sspram_param_if #(
    parameter int DATA_WIDTH = 2,
    parameter int ADDR_WIDTH = 4
);
    logic                  ce;
    logic                  we;
    logic [ADDR_WIDTH-1:0] ad;
    logic [DATA_WIDTH-1:0] di;
    logic [DATA_WIDTH-1:0] f;
    logic [DATA_WIDTH-1:0] q;
    logic                  busy;

    modport master (output ce, we, ad, di, input f, q, busy);
    modport slave  (input ce, we, ad, di, output f, q, busy);
endinterface

// File: rtl/sspram_param.sv
// Parametrised single-port distributed RAM slice with a combinational read port,
// a pipelined registered read port and an optional clear-to-INITVAL sequencer.
module sspram_param #(
    parameter int                                DATA_WIDTH     = 2,
    parameter int                                ADDR_WIDTH     = 4,
    parameter logic [DATA_WIDTH*(2**ADDR_WIDTH)-1:0] INITVAL    = '0,
    parameter string                             WRITEMODE      = "NORMAL",
    parameter bit                                OUTREG         = 1'b0,
    parameter string                             REGSET         = "RESET",
    parameter bit                                CLEAR_ON_RESET = 1'b0
) (
    input  logic           clk,
    input  logic           lsr,
    sspram_param_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [DATA_WIDTH-1:0]             REG_INIT   = (REGSET == "SET") ? '1 : '0;
    localparam logic [ADDR_WIDTH:0]               LAST_WORD  = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [DEPTH-1:0][DATA_WIDTH-1:0]  INIT_WORDS = INITVAL;

    typedef enum logic [1:0] {ST_RST, ST_CLR, ST_RDY} state_t;

    state_t                          state;
    logic                            busy_q;
    logic [ADDR_WIDTH:0]             cnt;
    logic [ADDR_WIDTH-1:0]           clr_ad;
    logic [DATA_WIDTH-1:0]           rd_word;
    logic [DATA_WIDTH-1:0]           r_q;
    logic [DATA_WIDTH-1:0]           q2_q;
    logic                            user_en;

    // NOTE: the array has no reset branch; it starts from INITVAL and LSR only
    // restarts the sequencer, so contents survive reset unless a clear runs.
    logic [DEPTH-1:0][DATA_WIDTH-1:0] mem = INITVAL;

    assign clr_ad  = cnt[ADDR_WIDTH-1:0];
    assign rd_word = mem[bus.ad];
    assign user_en = bus.ce && !busy_q;

    // Sequencer runs regardless of ce; the extra counter bit keeps it from wrapping.
    always_ff @(posedge clk or posedge lsr) begin
        if (lsr) begin
            state  <= ST_RST;
            busy_q <= 1'b1;
            cnt    <= '0;
        end else begin
            case (state)
                ST_RST: begin
                    if (CLEAR_ON_RESET) begin
                        state <= ST_CLR;
                    end else begin
                        state  <= ST_RDY;
                        busy_q <= 1'b0;
                    end
                end
                ST_CLR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_WORD) begin
                        state  <= ST_RDY;
                        busy_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == ST_CLR) begin
            mem[clr_ad] <= INIT_WORDS[clr_ad];
        end else if (user_en && bus.we) begin
            mem[bus.ad] <= bus.di;
        end
    end

    // rd_word is the pre-edge contents, which is exactly what read-before-write needs.
    always_ff @(posedge clk or posedge lsr) begin
        if (lsr) begin
            r_q  <= REG_INIT;
            q2_q <= REG_INIT;
        end else if (user_en) begin
            q2_q <= r_q;
            if (!bus.we) begin
                r_q <= rd_word;
            end else if (WRITEMODE == "WRITETHROUGH") begin
                r_q <= bus.di;
            end else if (WRITEMODE == "READBEFOREWRITE") begin
                r_q <= rd_word;
            end
        end
    end

    assign bus.f    = rd_word;
    assign bus.q    = OUTREG ? q2_q : r_q;
    assign bus.busy = busy_q;
endmodule

// File: tb/tb_sspram_param.sv
// Bench for sspram_param: three instances (NORMAL, WRITETHROUGH, READBEFOREWRITE
// with output register, SET and clear-on-reset) driven in lockstep.
module tb_sspram_param;
    localparam int DW = 4;
    localparam int AW = 4;
    localparam logic [63:0] INIT = 64'hFEDC_BA98_7654_3210;  // word n = n

    logic          clk = 1'b0;
    logic          lsr = 1'b1;
    logic          ce  = 1'b0;
    logic          we  = 1'b0;
    logic [AW-1:0] ad  = '0;
    logic [DW-1:0] di  = '0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    sspram_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_n ();
    sspram_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_wt ();
    sspram_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_rb ();

    assign bus_n.ce  = ce;  assign bus_n.we  = we;  assign bus_n.ad  = ad;  assign bus_n.di  = di;
    assign bus_wt.ce = ce;  assign bus_wt.we = we;  assign bus_wt.ad = ad;  assign bus_wt.di = di;
    assign bus_rb.ce = ce;  assign bus_rb.we = we;  assign bus_rb.ad = ad;  assign bus_rb.di = di;

    sspram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INITVAL(INIT), .WRITEMODE("NORMAL"),
                   .OUTREG(1'b0), .REGSET("RESET"), .CLEAR_ON_RESET(1'b0))
        u_n (.clk(clk), .lsr(lsr), .bus(bus_n));
    sspram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INITVAL(INIT), .WRITEMODE("WRITETHROUGH"),
                   .OUTREG(1'b0), .REGSET("RESET"), .CLEAR_ON_RESET(1'b0))
        u_wt (.clk(clk), .lsr(lsr), .bus(bus_wt));
    sspram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INITVAL(INIT), .WRITEMODE("READBEFOREWRITE"),
                   .OUTREG(1'b1), .REGSET("SET"), .CLEAR_ON_RESET(1'b1))
        u_rb (.clk(clk), .lsr(lsr), .bus(bus_rb));

    // f: expected pre-edge F; q_n/q_wt: Q after the edge; q_rb: two-stage Q after the edge.
    typedef struct {
        logic          ce;
        logic          we;
        logic [AW-1:0] ad;
        logic [DW-1:0] di;
        logic [DW-1:0] f;
        logic [DW-1:0] q_n;
        logic [DW-1:0] q_wt;
        logic [DW-1:0] q_rb;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_clear(input string tag);
        for (int k = 1; k <= 17; k++) begin
            tick();
            check($sformatf("%s busy edge %0d", tag, k), DW'(bus_rb.busy), (k <= 16) ? 4'd1 : 4'd0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 4'd3,  4'hA, 4'h3, 4'h0, 4'hA, 4'hF};
        vecs[1]  = '{1'b1, 1'b0, 4'd3,  4'h0, 4'hA, 4'hA, 4'hA, 4'h3};
        vecs[2]  = '{1'b1, 1'b0, 4'd3,  4'h0, 4'hA, 4'hA, 4'hA, 4'hA};
        vecs[3]  = '{1'b1, 1'b1, 4'd5,  4'h6, 4'h5, 4'hA, 4'h6, 4'hA};
        vecs[4]  = '{1'b1, 1'b0, 4'd5,  4'h0, 4'h6, 4'h6, 4'h6, 4'h5};
        vecs[5]  = '{1'b1, 1'b0, 4'd1,  4'h0, 4'h1, 4'h1, 4'h1, 4'h6};
        vecs[6]  = '{1'b1, 1'b1, 4'd5,  4'h9, 4'h6, 4'h1, 4'h9, 4'h1};
        vecs[7]  = '{1'b1, 1'b0, 4'd5,  4'h0, 4'h9, 4'h9, 4'h9, 4'h6};
        vecs[8]  = '{1'b0, 1'b1, 4'd2,  4'hF, 4'h2, 4'h9, 4'h9, 4'h6};
        vecs[9]  = '{1'b1, 1'b0, 4'd2,  4'h0, 4'h2, 4'h2, 4'h2, 4'h9};
        vecs[10] = '{1'b1, 1'b1, 4'd15, 4'h0, 4'hF, 4'h2, 4'h0, 4'h2};
        vecs[11] = '{1'b1, 1'b0, 4'd15, 4'h0, 4'h0, 4'h0, 4'h0, 4'hF};
        vecs[12] = '{1'b1, 1'b1, 4'd0,  4'hC, 4'h0, 4'h0, 4'hC, 4'h0};
        vecs[13] = '{1'b1, 1'b0, 4'd0,  4'h0, 4'hC, 4'hC, 4'hC, 4'h0};

        // Reset state, sampled between edges while lsr is held.
        ad = 4'd3;
        #12;
        check("reset q_n",     bus_n.q,  4'h0);
        check("reset q_wt",    bus_wt.q, 4'h0);
        check("reset q_rb",    bus_rb.q, 4'hF);
        check("reset busy_n",  DW'(bus_n.busy),  4'd1);
        check("reset busy_rb", DW'(bus_rb.busy), 4'd1);
        check("reset f",       bus_n.f,  4'h3);
        lsr = 1'b0;

        begin : wait_ready
            int n = 0;
            while ((bus_n.busy || bus_wt.busy || bus_rb.busy) && n < 40) begin
                tick();
                n++;
            end
            check("ready after reset", DW'(bus_n.busy || bus_wt.busy || bus_rb.busy), 4'd0);
        end
        check("idle q_n",  bus_n.q,  4'h0);
        check("idle q_rb", bus_rb.q, 4'hF);

        // Table: write/read latency, write modes, ce=0 hold, top and bottom addresses.
        for (int i = 0; i < 14; i++) begin
            ce = vecs[i].ce;  we = vecs[i].we;  ad = vecs[i].ad;  di = vecs[i].di;
            #1;
            check($sformatf("v%0d f_n", i),  bus_n.f,  vecs[i].f);
            check($sformatf("v%0d f_rb", i), bus_rb.f, vecs[i].f);
            tick();
            check($sformatf("v%0d q_n", i),  bus_n.q,  vecs[i].q_n);
            check($sformatf("v%0d q_wt", i), bus_wt.q, vecs[i].q_wt);
            check($sformatf("v%0d q_rb", i), bus_rb.q, vecs[i].q_rb);
        end
        ce = 1'b0;  we = 1'b0;

        // Asynchronous reset between edges; memory keeps dirtied word 3.
        #3;
        lsr = 1'b1;
        ad  = 4'd3;
        #1;
        check("async q_n",  bus_n.q,  4'h0);
        check("async q_wt", bus_wt.q, 4'h0);
        check("async q_rb", bus_rb.q, 4'hF);
        check("async f kept", bus_rb.f, 4'hA);

        // Clear sequence with a write attempt held throughout the busy window.
        ce = 1'b1;  we = 1'b1;  ad = 4'd4;  di = 4'h7;
        lsr = 1'b0;
        run_clear("clr");
        we = 1'b0;
        for (int a = 0; a < 16; a++) begin
            ad = AW'(a);
            #1;
            check($sformatf("clr f[%0d]", a), bus_rb.f, DW'(a));
        end

        // Dirty words 0 and 10, then abort a clear after word 6 has been rewritten.
        we = 1'b1;  ad = 4'd0;  di = 4'h5;
        tick();
        ad = 4'd10;  di = 4'hE;
        tick();
        we = 1'b0;
        #2;
        lsr = 1'b1;
        #1;
        lsr = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("abort busy edge %0d", k), DW'(bus_rb.busy), 4'd1);
        end
        lsr = 1'b1;
        ad  = 4'd0;
        #1;
        check("abort f[0] cleared", bus_rb.f, 4'h0);
        ad = 4'd10;
        #1;
        check("abort f[10] pending", bus_rb.f, 4'hE);
        for (int k = 1; k <= 2; k++) begin
            tick();
            check($sformatf("held busy %0d", k), DW'(bus_rb.busy), 4'd1);
            check($sformatf("held q_rb %0d", k), bus_rb.q, 4'hF);
        end
        lsr = 1'b0;
        run_clear("reclr");
        ad = 4'd10;
        #1;
        check("reclr f[10]", bus_rb.f, 4'hA);
        ad = 4'd7;
        #1;
        check("reclr f[7]", bus_rb.f, 4'h7);
        ad = 4'd0;
        #1;
        check("reclr f[0]", bus_rb.f, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
